// File: rtl/bram_arb_pkg.sv
// Shared types and defaults for the BRAM port arbiter.
// Optional feature macro: BRAM_ARB_FWD_EN (same-cycle write-to-read forwarding).
package bram_arb_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned DefNumReq    = 2;
  localparam int unsigned MaxNumReq    = 4;
  // Sized for the largest legal requester count so one type serves every build.
  localparam int unsigned ReqIdWidth   = $clog2(MaxNumReq);

  typedef logic [ReqIdWidth-1:0] req_id_t;

  // Registered read-response stage.
  typedef struct packed {
    logic                    pend;
    req_id_t                 id;
    logic                    fwd;
    logic [DefDataWidth-1:0] fwd_data;
  } rsp_stage_t;

  // Round-robin pointer advance: one past the granted requester, modulo n.
  function automatic req_id_t next_ptr(input req_id_t id, input int unsigned n);
    return (int'(id) + 1 >= int'(n)) ? '0 : req_id_t'(id + 1'b1);
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus of the BRAM port arbiter: request handshake and read response.
// Names are from the arbiter's point of view.
interface bram_port_arbiter_if
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DefNumReq,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth
);
  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ-1:0]            i_req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic [NUM_REQ-1:0]            o_rsp_valid;
  logic [DATA_WIDTH-1:0]         o_rsp_data;

  modport master (
    output i_req_valid, i_req_write, i_req_addr, i_req_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data
  );

  modport slave (
    input  i_req_valid, i_req_write, i_req_addr, i_req_data,
    output o_req_ready, o_rsp_valid, o_rsp_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after i_ptr, wrapping modulo N.
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned N = DefNumReq
) (
  input  logic [N-1:0] i_req,
  input  req_id_t      i_ptr,
  output logic [N-1:0] o_grant,
  output req_id_t      o_grant_id,
  output logic         o_grant_any
);

  // Two passes: indices >= ptr first, then the wrapped-around indices below ptr.
  always_comb begin
    o_grant     = '0;
    o_grant_id  = '0;
    o_grant_any = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      if (!o_grant_any && (k >= int'(i_ptr)) && i_req[k]) begin
        o_grant[k]  = 1'b1;
        o_grant_id  = req_id_t'(k);
        o_grant_any = 1'b1;
      end
    end
    for (int k = 0; k < int'(N); k++) begin
      if (!o_grant_any && (k < int'(i_ptr)) && i_req[k]) begin
        o_grant[k]  = 1'b1;
        o_grant_id  = req_id_t'(k);
        o_grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM (one write port, one read port) among NUM_REQ requesters with an
// independent round-robin arbiter per port; read data returns one cycle after grant.
// Optional feature macro: BRAM_ARB_FWD_EN forwards same-cycle same-address write data.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned NUM_REQ    = DefNumReq
) (
  input  logic                  CLK,
  input  logic                  RST,
  bram_port_arbiter_if.slave    req_if,
  output logic                  o_bram_write,
  output logic [ADDR_WIDTH-1:0] o_bram_wrt_addr,
  output logic [DATA_WIDTH-1:0] o_bram_data,
  output logic                  o_bram_read,
  output logic [ADDR_WIDTH-1:0] o_bram_read_addr,
  input  logic [DATA_WIDTH-1:0] i_bram_data
);

  logic                  r_active;
  req_id_t               r_wr_ptr, r_rd_ptr;
  rsp_stage_t            r_rsp;
  rsp_stage_t            w_rsp_nxt;
  logic [NUM_REQ-1:0]    w_wr_req, w_rd_req, w_wr_grant, w_rd_grant;
  req_id_t               w_wr_id, w_rd_id;
  logic                  w_wr_any, w_rd_any;
  logic [ADDR_WIDTH-1:0] w_wr_addr, w_rd_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;

  // r_active holds off all grants during reset and the first cycle after release.
  assign w_wr_req = r_active ? (req_if.i_req_valid &  req_if.i_req_write) : '0;
  assign w_rd_req = r_active ? (req_if.i_req_valid & ~req_if.i_req_write) : '0;

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .i_req       (w_wr_req),
    .i_ptr       (r_wr_ptr),
    .o_grant     (w_wr_grant),
    .o_grant_id  (w_wr_id),
    .o_grant_any (w_wr_any)
  );

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .i_req       (w_rd_req),
    .i_ptr       (r_rd_ptr),
    .o_grant     (w_rd_grant),
    .o_grant_id  (w_rd_id),
    .o_grant_any (w_rd_any)
  );

  assign req_if.o_req_ready = w_wr_grant | w_rd_grant;

  // Select the granted address/data by one-hot grant; zero when nothing is granted.
  always_comb begin
    w_wr_addr = '0;
    w_wr_data = '0;
    w_rd_addr = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (w_wr_grant[k]) begin
        w_wr_addr = req_if.i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        w_wr_data = req_if.i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
      if (w_rd_grant[k]) begin
        w_rd_addr = req_if.i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign o_bram_write     = w_wr_any;
  assign o_bram_wrt_addr  = w_wr_addr;
  assign o_bram_data      = w_wr_data;
  assign o_bram_read      = w_rd_any;
  assign o_bram_read_addr = w_rd_addr;

  // Next response-stage contents, including the optional forward capture.
  always_comb begin
    w_rsp_nxt      = '0;
    w_rsp_nxt.pend = w_rd_any;
    w_rsp_nxt.id   = w_rd_id;
`ifdef BRAM_ARB_FWD_EN
    w_rsp_nxt.fwd      = w_wr_any && w_rd_any && (w_wr_addr == w_rd_addr);
    w_rsp_nxt.fwd_data = DefDataWidth'(w_wr_data);
`else
    w_rsp_nxt.fwd      = 1'b0;
    w_rsp_nxt.fwd_data = '0;
`endif
  end

  // Pointers, response stage and the post-reset enable; reset drops any pending read.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_active <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_rsp    <= '0;
    end else begin
      r_active <= 1'b1;
      if (w_wr_any) r_wr_ptr <= next_ptr(w_wr_id, NUM_REQ);
      if (w_rd_any) r_rd_ptr <= next_ptr(w_rd_id, NUM_REQ);
      r_rsp <= w_rsp_nxt;
    end
  end

  // Route the response to its issuer; data is zero when no response is valid.
  always_comb begin
    req_if.o_rsp_valid = '0;
    req_if.o_rsp_data  = '0;
    if (r_rsp.pend) begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        if (r_rsp.id == req_id_t'(k)) req_if.o_rsp_valid[k] = 1'b1;
      end
      req_if.o_rsp_data = r_rsp.fwd ? DATA_WIDTH'(r_rsp.fwd_data) : i_bram_data;
    end
  end

endmodule
